// File: rtl/lavadora_pkg.sv
// Shared types for the washer sequencer: state and service encodings and
// the actuator vector driven in each state.
package lavadora_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LOCK,
    FILL,
    WASH,
    RINSE,
    DRAIN,
    SPIN,
    DRY,
    DONE,
    ABORT
  } state_e;

  typedef enum logic [1:0] {
    SVC_NONE,
    SVC_SECADO,
    SVC_LAVADO,
    SVC_PESADO
  } svc_e;

  typedef struct packed {
    logic door_lock;
    logic valve_fill;
    logic motor_wash;
    logic motor_spin;
    logic heater;
    logic drain_pump;
  } act_t;

  localparam act_t ACT_OFF   = act_t'(6'b000000);
  localparam act_t ACT_LOCK  = act_t'(6'b100000);
  localparam act_t ACT_FILL  = act_t'(6'b110000);
  localparam act_t ACT_WASH  = act_t'(6'b101000);
  localparam act_t ACT_DRAIN = act_t'(6'b100001);
  localparam act_t ACT_SPIN  = act_t'(6'b100101);
  localparam act_t ACT_DRY   = act_t'(6'b100110);
  localparam act_t ACT_ABORT = act_t'(6'b000001);

  function automatic act_t act_decode(input state_e s);
    act_t a;
    a = ACT_OFF;
    case (s)
      LOCK:        a = ACT_LOCK;
      FILL:        a = ACT_FILL;
      WASH, RINSE: a = ACT_WASH;
      DRAIN:       a = ACT_DRAIN;
      SPIN:        a = ACT_SPIN;
      DRY:         a = ACT_DRY;
      ABORT:       a = ACT_ABORT;
      default:     a = ACT_OFF;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/lavadora_timer.sv
// Phase timer: a TICK_DIV prescaler feeding a tick down-counter. load restarts
// both; expire is high during the final clock cycle of the loaded duration.
module lavadora_timer #(
  parameter int TICK_DIV = 4,
  parameter int TW       = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [TW-1:0] dur,
  output logic          expire
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_reg;
  logic [TW-1:0] ticks_reg;
  logic          tick;

  assign tick   = (presc_reg == PRESC_LAST);
  assign expire = tick && (ticks_reg == TW'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_reg <= '0;
      ticks_reg <= '0;
    end else if (load) begin
      presc_reg <= '0;
      // A zero duration still has to last one tick.
      ticks_reg <= (dur == '0) ? TW'(1) : dur;
    end else if (ticks_reg != '0) begin
      if (tick) begin
        presc_reg <= '0;
        ticks_reg <= ticks_reg - TW'(1);
      end else begin
        presc_reg <= presc_reg + PW'(1);
      end
    end
  end

endmodule

// File: rtl/lavadora_secuenciador.sv
// Washer phase sequencer: turns a one-cycle service grant into the timed
// actuator sequence. Define LAVADORA_PREWASH_EN to add a prewash pass to pesado.
module lavadora_secuenciador #(
  parameter int TICK_DIV = 4,
  parameter int TW       = 16,
  parameter int T_LOCK   = 2,
  parameter int T_FILL   = 6,
  parameter int T_WASH   = 10,
  parameter int T_RINSE  = 5,
  parameter int T_DRAIN  = 4,
  parameter int T_SPIN   = 6,
  parameter int T_DRY    = 12
) (
  input  logic clk,
  input  logic reset,
  input  logic req_secado,
  input  logic req_lavado,
  input  logic req_pesado,
  input  logic door_closed,
  output logic door_lock,
  output logic valve_fill,
  output logic motor_wash,
  output logic motor_spin,
  output logic heater,
  output logic drain_pump,
  output logic busy,
  output logic done,
  output logic aborted,
  output logic req_err
);

  import lavadora_pkg::*;

`ifdef LAVADORA_PREWASH_EN
  localparam logic [1:0] HEAVY_PASS = 2'd1;
  localparam logic [1:0] RINSE_PASS = 2'd2;
`else
  localparam logic [1:0] HEAVY_PASS = 2'd0;
  localparam logic [1:0] RINSE_PASS = 2'd1;
`endif

  // Doubled wash is formed one bit wider so overflow saturates instead of wrapping.
  localparam logic [TW:0]   WASH_X2    = {1'b0, TW'(T_WASH)} << 1;
  localparam logic [TW-1:0] WASH_HEAVY = WASH_X2[TW] ? '1 : WASH_X2[TW-1:0];

  state_e      state_reg, state_next;
  svc_e        svc_reg, svc_next;
  logic [1:0]  pass_reg, pass_next;
  act_t        act_reg;
  logic        busy_reg, done_reg, aborted_reg, req_err_reg;
  logic        req_any, req_one;
  logic        accept, reject, abort_set;
  logic        tmr_load, tmr_expire;
  logic [TW-1:0] dur_next;

  assign req_any = req_secado | req_lavado | req_pesado;
  assign req_one = ($countones({req_secado, req_lavado, req_pesado}) == 1);

  always_comb begin
    state_next = state_reg;
    svc_next   = svc_reg;
    pass_next  = pass_reg;
    accept     = 1'b0;
    reject     = 1'b0;
    abort_set  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_any) begin
          if (req_one && door_closed) begin
            accept     = 1'b1;
            pass_next  = 2'd0;
            state_next = LOCK;
            if (req_secado)      svc_next = SVC_SECADO;
            else if (req_lavado) svc_next = SVC_LAVADO;
            else                 svc_next = SVC_PESADO;
          end else begin
            reject = 1'b1;
          end
        end
      end
      ABORT: if (tmr_expire) state_next = IDLE;
      DONE:  state_next = IDLE;
      default: begin
        if (!door_closed) begin
          abort_set  = 1'b1;
          state_next = ABORT;
        end else if (tmr_expire) begin
          case (state_reg)
            LOCK:  state_next = (svc_reg == SVC_SECADO) ? DRY : FILL;
            FILL:  state_next = (svc_reg == SVC_PESADO && pass_reg == RINSE_PASS) ? RINSE : WASH;
            WASH, RINSE: state_next = DRAIN;
            DRAIN: begin
              pass_next  = pass_reg + 2'd1;
              state_next = (svc_reg == SVC_PESADO && pass_reg != RINSE_PASS) ? FILL : SPIN;
            end
            SPIN, DRY: state_next = DONE;
            default:   state_next = IDLE;
          endcase
        end
      end
    endcase
  end

  // Duration of the phase being entered; only sampled when tmr_load is high.
  always_comb begin
    dur_next = '0;
    case (state_next)
      LOCK:  dur_next = TW'(T_LOCK);
      FILL:  dur_next = TW'(T_FILL);
      WASH:  dur_next = (svc_next == SVC_PESADO && pass_next == HEAVY_PASS) ? WASH_HEAVY : TW'(T_WASH);
      RINSE: dur_next = TW'(T_RINSE);
      DRAIN, ABORT: dur_next = TW'(T_DRAIN);
      SPIN:  dur_next = TW'(T_SPIN);
      DRY:   dur_next = TW'(T_DRY);
      default: dur_next = '0;
    endcase
  end

  assign tmr_load = (state_next != state_reg);

  lavadora_timer #(
    .TICK_DIV(TICK_DIV),
    .TW      (TW)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (tmr_load),
    .dur   (dur_next),
    .expire(tmr_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      svc_reg   <= SVC_NONE;
      pass_reg  <= 2'd0;
    end else begin
      state_reg <= state_next;
      svc_reg   <= svc_next;
      pass_reg  <= pass_next;
    end
  end

  // Outputs decode the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      act_reg     <= ACT_OFF;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      aborted_reg <= 1'b0;
      req_err_reg <= 1'b0;
    end else begin
      act_reg     <= act_decode(state_next);
      busy_reg    <= (state_next != IDLE);
      done_reg    <= (state_next == DONE);
      req_err_reg <= reject;
      if (abort_set)   aborted_reg <= 1'b1;
      else if (accept) aborted_reg <= 1'b0;
    end
  end

  assign door_lock  = act_reg.door_lock;
  assign valve_fill = act_reg.valve_fill;
  assign motor_wash = act_reg.motor_wash;
  assign motor_spin = act_reg.motor_spin;
  assign heater     = act_reg.heater;
  assign drain_pump = act_reg.drain_pump;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign aborted    = aborted_reg;
  assign req_err    = req_err_reg;

endmodule

// File: tb/tb_lavadora_secuenciador.sv
// Bench for lavadora_secuenciador: per-cycle vector table on a fast-tick
// instance, plus full pesado phase traces on that and a saturating instance.
module tb_lavadora_secuenciador;

  localparam logic [9:0] E_IDLE  = 10'b0000000000;
  localparam logic [9:0] E_LOCK  = 10'b1000001000;
  localparam logic [9:0] E_FILL  = 10'b1100001000;
  localparam logic [9:0] E_WASH  = 10'b1010001000;
  localparam logic [9:0] E_DRAIN = 10'b1000011000;
  localparam logic [9:0] E_SPIN  = 10'b1001011000;
  localparam logic [9:0] E_DRY   = 10'b1001101000;
  localparam logic [9:0] E_DONE  = 10'b0000001100;
  localparam logic [9:0] E_ABORT = 10'b0000011010;
  localparam logic [9:0] E_ERR   = 10'b0000000001;
  localparam logic [9:0] E_ABTID = 10'b0000000010;

  localparam int P_IDLE = 0, P_LOCK = 1, P_FILL = 2, P_WASH = 3, P_DRAIN = 4;
  localparam int P_SPIN = 5, P_DRY = 6, P_ABORT = 7, P_DONE = 8, P_BAD = 9;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req_secado = 1'b0, req_lavado = 1'b0, req_pesado = 1'b0, door_closed = 1'b1;
  logic door_lock, valve_fill, motor_wash, motor_spin, heater, drain_pump;
  logic busy, done, aborted, req_err;
  logic b_req_secado = 1'b0, b_req_lavado = 1'b0, b_req_pesado = 1'b0, b_door_closed = 1'b1;
  logic b_door_lock, b_valve_fill, b_motor_wash, b_motor_spin, b_heater, b_drain_pump;
  logic b_busy, b_done, b_aborted, b_req_err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  lavadora_secuenciador #(.TICK_DIV(2), .T_DRY(3)) dut (
    .clk(clk), .reset(reset), .req_secado(req_secado), .req_lavado(req_lavado),
    .req_pesado(req_pesado), .door_closed(door_closed), .door_lock(door_lock),
    .valve_fill(valve_fill), .motor_wash(motor_wash), .motor_spin(motor_spin),
    .heater(heater), .drain_pump(drain_pump), .busy(busy), .done(done),
    .aborted(aborted), .req_err(req_err)
  );

  // Single-cycle ticks, 4-bit timer (heavy wash saturates at 15), zero-length spin.
  lavadora_secuenciador #(.TICK_DIV(1), .TW(4), .T_SPIN(0)) dut_b (
    .clk(clk), .reset(reset), .req_secado(b_req_secado), .req_lavado(b_req_lavado),
    .req_pesado(b_req_pesado), .door_closed(b_door_closed), .door_lock(b_door_lock),
    .valve_fill(b_valve_fill), .motor_wash(b_motor_wash), .motor_spin(b_motor_spin),
    .heater(b_heater), .drain_pump(b_drain_pump), .busy(b_busy), .done(b_done),
    .aborted(b_aborted), .req_err(b_req_err)
  );

  typedef struct {
    logic       rst;
    logic [2:0] req;   // {secado, lavado, pesado}
    logic       door;
    int         n;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs[$];
  int exp_code[$];
  int exp_len[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h", name, got, want);
  endtask

  task automatic add(input logic rst, input logic [2:0] req, input logic door,
                     input int n, input logic [9:0] exp);
    vec_t v;
    v.rst = rst; v.req = req; v.door = door; v.n = n; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic seg(input int code, input int len);
    exp_code.push_back(code);
    exp_len.push_back(len);
  endtask

  function automatic int phase_of(input logic [5:0] act, input logic dn);
    if (dn) return P_DONE;
    case (act)
      6'b000000: return P_IDLE;
      6'b100000: return P_LOCK;
      6'b110000: return P_FILL;
      6'b101000: return P_WASH;
      6'b100001: return P_DRAIN;
      6'b100101: return P_SPIN;
      6'b100110: return P_DRY;
      6'b000001: return P_ABORT;
      default:   return P_BAD;
    endcase
  endfunction

  function automatic int cur_phase(input int which);
    if (which == 0)
      return phase_of({door_lock, valve_fill, motor_wash, motor_spin, heater, drain_pump}, done);
    return phase_of({b_door_lock, b_valve_fill, b_motor_wash, b_motor_spin, b_heater, b_drain_pump}, b_done);
  endfunction

  // Pulse req_pesado on one instance and compare the run-length phase trace.
  task automatic run_trace(input int which, input string tag);
    int seg_code[$];
    int seg_len[$];
    int cyc, ph, total;
    if (which == 0) req_pesado = 1'b1; else b_req_pesado = 1'b1;
    @(posedge clk); #1;
    req_pesado = 1'b0; b_req_pesado = 1'b0;
    cyc = 0;
    ph = cur_phase(which);
    while (ph != P_IDLE && cyc < 2000) begin
      if (seg_code.size() > 0 && seg_code[seg_code.size()-1] == ph)
        seg_len[seg_len.size()-1] += 1;
      else begin
        seg_code.push_back(ph);
        seg_len.push_back(1);
      end
      @(posedge clk); #1;
      ph = cur_phase(which);
      cyc++;
    end
    check($sformatf("%s.returns_idle", tag), ph, P_IDLE);
    check($sformatf("%s.n_phases", tag), seg_code.size(), exp_code.size());
    total = 0;
    foreach (exp_len[i]) total += exp_len[i];
    check($sformatf("%s.total_cycles", tag), cyc, total);
    for (int i = 0; i < exp_code.size() && i < seg_code.size(); i++) begin
      check($sformatf("%s.phase%0d.code", tag, i), seg_code[i], exp_code[i]);
      check($sformatf("%s.phase%0d.len", tag, i), seg_len[i], exp_len[i]);
    end
    $display("trace %s: %0d phases, %0d busy cycles", tag, seg_code.size(), cyc);
  endtask

  initial begin
    logic [9:0] got;

    add(1, 3'b000, 1, 2, E_IDLE);
    // secado: LOCK 2 ticks, DRY 3 ticks, at 2 cycles per tick
    add(0, 3'b100, 1, 1, E_LOCK);
    add(0, 3'b000, 1, 3, E_LOCK);
    add(0, 3'b000, 1, 6, E_DRY);
    add(0, 3'b000, 1, 1, E_DONE);
    add(0, 3'b000, 1, 2, E_IDLE);
    // rejected requests
    add(0, 3'b011, 1, 1, E_ERR);
    add(0, 3'b000, 1, 1, E_IDLE);
    add(0, 3'b010, 0, 1, E_ERR);
    add(0, 3'b000, 0, 1, E_IDLE);
    add(0, 3'b111, 1, 1, E_ERR);
    // lavado, extra request while busy ignored, door opened mid-WASH
    add(0, 3'b010, 1, 1, E_LOCK);
    add(0, 3'b001, 1, 1, E_LOCK);
    add(0, 3'b000, 1, 2, E_LOCK);
    add(0, 3'b000, 1, 12, E_FILL);
    add(0, 3'b000, 1, 5, E_WASH);
    add(0, 3'b000, 0, 1, E_ABORT);
    add(0, 3'b000, 0, 7, E_ABORT);
    add(0, 3'b000, 1, 2, E_ABTID);
    // next accepted request clears aborted
    add(0, 3'b100, 1, 1, E_LOCK);
    add(0, 3'b000, 1, 3, E_LOCK);
    add(0, 3'b000, 1, 6, E_DRY);
    add(0, 3'b000, 1, 1, E_DONE);
    add(0, 3'b000, 1, 1, E_IDLE);
    // lavado up to SPIN, then reset with a concurrent request
    add(0, 3'b010, 1, 1, E_LOCK);
    add(0, 3'b000, 1, 3, E_LOCK);
    add(0, 3'b000, 1, 12, E_FILL);
    add(0, 3'b000, 1, 20, E_WASH);
    add(0, 3'b000, 1, 8, E_DRAIN);
    add(0, 3'b000, 1, 3, E_SPIN);
    add(1, 3'b100, 1, 1, E_IDLE);
    add(0, 3'b000, 1, 1, E_IDLE);
    add(0, 3'b100, 1, 1, E_LOCK);
    add(0, 3'b000, 1, 3, E_LOCK);
    add(0, 3'b000, 1, 6, E_DRY);
    add(0, 3'b000, 1, 1, E_DONE);
    add(0, 3'b000, 1, 1, E_IDLE);

    for (int i = 0; i < vecs.size(); i++) begin
      for (int k = 0; k < vecs[i].n; k++) begin
        reset = vecs[i].rst;
        {req_secado, req_lavado, req_pesado} = vecs[i].req;
        door_closed = vecs[i].door;
        @(posedge clk); #1;
        got = {door_lock, valve_fill, motor_wash, motor_spin, heater, drain_pump,
               busy, done, aborted, req_err};
        check($sformatf("vec%0d.%0d", i, k), 32'(got), 32'(vecs[i].exp));
      end
      $display("vec %0d: rst=%b req=%b door=%b x%0d exp=%b", i, vecs[i].rst,
               vecs[i].req, vecs[i].door, vecs[i].n, vecs[i].exp);
    end
    reset = 1'b0;
    {req_secado, req_lavado, req_pesado} = 3'b000;
    door_closed = 1'b1;

    exp_code.delete(); exp_len.delete();
    seg(P_LOCK, 4); seg(P_FILL, 12);
`ifdef LAVADORA_PREWASH_EN
    seg(P_WASH, 20); seg(P_DRAIN, 8); seg(P_FILL, 12);
`endif
    seg(P_WASH, 40); seg(P_DRAIN, 8); seg(P_FILL, 12); seg(P_WASH, 10);
    seg(P_DRAIN, 8); seg(P_SPIN, 12); seg(P_DONE, 1);
    run_trace(0, "pesado");

    exp_code.delete(); exp_len.delete();
    seg(P_LOCK, 2); seg(P_FILL, 6);
`ifdef LAVADORA_PREWASH_EN
    seg(P_WASH, 10); seg(P_DRAIN, 4); seg(P_FILL, 6);
`endif
    seg(P_WASH, 15); seg(P_DRAIN, 4); seg(P_FILL, 6); seg(P_WASH, 5);
    seg(P_DRAIN, 4); seg(P_SPIN, 1); seg(P_DONE, 1);
    run_trace(1, "pesado_sat");
    check("b.aborted", 32'(b_aborted), 32'(0));
    check("b.req_err", 32'(b_req_err), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
